bus_mux_n: RTL

BUS_MUX_N -- requirements
Module: bus_mux_n

---
 rtl/bus_mux_n.sv | 80 ++++++++
 1 files changed

// File: rtl/bus_mux_n.sv
// Registered N-source bus multiplexer with lowest-index priority and conflict detection.
// Optional saturating conflict counter is enabled by defining BUS_MUX_CONFLICT_CNT_EN.
module bus_mux_n #(
    parameter int unsigned             WIDTH     = 32,
    parameter int unsigned             NUM_SRC   = 32,
    parameter int unsigned             IDLE_HOLD = 0,
    parameter logic [WIDTH-1:0]        IDLE_VAL  = '1,
    localparam int unsigned            SEL_W     = ($clog2(NUM_SRC) < 1) ? 1 : int'($clog2(NUM_SRC))
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       stall,
    input  logic [NUM_SRC-1:0]         src_en,
    input  logic [NUM_SRC*WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]           bus_out,
    output logic                       bus_valid,
    output logic [SEL_W-1:0]           bus_src,
    output logic                       conflict,
    output logic [7:0]                 conflict_cnt
);

    logic [SEL_W-1:0] win_idx;
    logic [WIDTH-1:0] win_data;
    logic             any_en;
    logic             multi_en;

    // Lowest set enable wins; scanning downward lets the lowest index overwrite last.
    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                win_idx  = SEL_W'(i);
                win_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign any_en   = |src_en;
    assign multi_en = |(src_en & (src_en - NUM_SRC'(1)));

    // conflict is a pulse, so it drops to 0 on stalled cycles while everything else holds.
    always_ff @(posedge clk) begin
        if (clr) begin
            bus_out   <= IDLE_VAL;
            bus_valid <= 1'b0;
            bus_src   <= '0;
            conflict  <= 1'b0;
        end else begin
            conflict <= 1'b0;
            if (!stall) begin
                conflict <= multi_en;
                if (any_en) begin
                    bus_out   <= win_data;
                    bus_valid <= 1'b1;
                    bus_src   <= win_idx;
                end else begin
                    bus_valid <= 1'b0;
                    if (IDLE_HOLD == 0) begin
                        bus_out <= IDLE_VAL;
                    end
                end
            end
        end
    end

`ifdef BUS_MUX_CONFLICT_CNT_EN
    // Saturating count of accepted conflict cycles.
    always_ff @(posedge clk) begin
        if (clr) begin
            conflict_cnt <= 8'd0;
        end else if (!stall && multi_en && conflict_cnt != 8'hFF) begin
            conflict_cnt <= conflict_cnt + 8'd1;
        end
    end
`else
    assign conflict_cnt = 8'd0;
`endif

endmodule
